sj_input_stage: RTL and testbench
=================================

// Module: sj_input_stage
// PURPOSE
//  Upstream front-end for the SJ core. Synchronises the raw readA/readB pad buses
//  and filters glitches by requiring STABLE_CYCLES of stability. Each accepted change
//  of the {A,B} pair is queued in a small FIFO. The core drains it with valid/ready.
// PARAMETERS
//  WIDTH          8  width of each of the A and B buses
//  STABLE_CYCLES  4  consecutive equal synced samples required to accept a value (>=2)
//  DEPTH          4  FIFO entries (power of two, >=2)
// PORTS
//  clk        in   1              single clock, rising edge
//  RST        in   1              asynchronous reset, active-high
//  readA_pad  in   WIDTH          raw A bus from pins (asynchronous)
//  readB_pad  in   WIDTH          raw B bus from pins (asynchronous)
//  readA      out  WIDTH          A field of FIFO head entry
//  readB      out  WIDTH          B field of FIFO head entry
//  out_valid  out  1              head entry valid
//  out_ready  in   1              core accepts head; pop when out_valid && out_ready
//  count      out  clog2(DEPTH+1) current FIFO occupancy
//  overflow   out  1              sticky: an accepted sample was dropped while FIFO full
// BEHAVIOUR
//  Reset (async, RST=1):
//  - all flops clear; readA=readB=0, out_valid=0, count=0, overflow=0
//  - last_accepted={0,0}; filter state IDLE
//  - RST mid-operation discards queued entries and any in-progress filter count
//  Sync: 2-flop synchroniser per bit on both buses; s2 = synced {A,B} (2*WIDTH bits)
//  Filter FSM (state, cand, cnt):
//  - IDLE: s2==last_accepted -> stay. Else cand<=s2, cnt<=1 -> SETTLE
//  - SETTLE, s2!=cand: cand<=s2, cnt<=1
//    - if s2==last_accepted -> IDLE
//  - SETTLE, s2==cand: cnt<=cnt+1; when cnt+1==STABLE_CYCLES -> COMMIT
//  - COMMIT (1 cycle): push cand, last_accepted<=cand -> IDLE
//    - s2 is not examined in COMMIT; a change is seen next cycle from IDLE
//  - Returning to last_accepted before commit produces no push (glitch rejected)
//  FIFO:
//  - DEPTH entries of {A,B}; rd/wr pointers wrap modulo DEPTH
//  - count in 0..DEPTH
//  - push when COMMIT && (count<DEPTH || pop this cycle)
//  - full and COMMIT with no pop: sample dropped, overflow<=1 (cleared only by RST)
//  - simultaneous push+pop: count unchanged; both take effect
//  - pop when empty: impossible by protocol (out_valid=0); ignored
//  - out_valid = (count!=0), registered; no same-cycle bypass
//  - readA/readB = head entry; stable while out_valid && !out_ready
//  Latency:
//  - pad change to out_valid = STABLE_CYCLES+3 clk edges with empty FIFO (7 at defaults)
//  - sustained throughput: at most one accepted sample per STABLE_CYCLES+1 cycles
// CONFIGURATION
//  SJ_IN_OVF_CNT_EN defined:
//  - adds output ovf_count [7:0]: count of dropped samples, saturates at 255
//  - reset to 0 by RST only
//  - overflow = (ovf_count!=0)
//  SJ_IN_OVF_CNT_EN undefined:
//  - ovf_count port and counter absent; overflow is a single sticky flop
// TESTING
//  1 RST=1 mid-run, pads=8'hFF/8'hFF -> all outputs 0 while RST; no push until pads held >=4 cycles after RST falls
//  2 A=8'h3C,B=8'h5A held, out_ready=1 -> out_valid rises 7 cycles after change with readA=3C,readB=5A; one push only
//  3 A toggles 00->11 for 3 cycles then back to 00 -> no push, out_valid stays 0
//  4 out_ready=0; apply 5 distinct stable values 01..05 -> count=4, head=01 held, overflow=1; drain -> 01,02,03,04
//  5 count=4, COMMIT coincides with pop -> no drop, overflow stays 0, count stays 4
//  6 (SJ_IN_OVF_CNT_EN) 300 drops with out_ready=0 -> ovf_count=255, overflow=1

Source files
------------

// File: rtl/sj_input_stage.sv
// Pad input front-end: 2-flop sync, STABLE_CYCLES glitch filter, DEPTH-entry {A,B} FIFO.
// Latency: pad change to out_valid is STABLE_CYCLES+3 edges into an empty FIFO.
// Backpressure: head held while out_ready=0; commits into a full FIFO are dropped and flagged.
// Optional feature macro SJ_IN_OVF_CNT_EN adds a saturating 8-bit drop counter (ovf_count).
module sj_input_stage #(
   parameter int WIDTH         = 8,
   parameter int STABLE_CYCLES = 4,
   parameter int DEPTH         = 4
) (
   input  logic                       clk,
   input  logic                       RST,
   input  logic [WIDTH-1:0]           readA_pad,
   input  logic [WIDTH-1:0]           readB_pad,
   output logic [WIDTH-1:0]           readA,
   output logic [WIDTH-1:0]           readB,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow
`ifdef SJ_IN_OVF_CNT_EN
   ,
   output logic [7:0]                 ovf_count
`endif
);

   localparam int PW   = 2 * WIDTH;
   localparam int CNTW = $clog2(DEPTH + 1);
   localparam int PTRW = $clog2(DEPTH);
   localparam int FW   = $clog2(STABLE_CYCLES + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, COMMIT = 2'd2} state_t;

   logic [PW-1:0]   s1, s2;
   state_t          state, state_n;
   logic [PW-1:0]   cand, cand_n;
   logic [FW-1:0]   cnt, cnt_n;
   logic [PW-1:0]   last_accepted;
   logic            commit;

   logic [PW-1:0]   mem [DEPTH];
   logic [PTRW-1:0] rd_ptr, wr_ptr;
   logic [CNTW-1:0] count_n;
   logic            pop, push, drop;
   logic [PW-1:0]   head;

   // Two-flop synchroniser on the concatenated {A,B} pad bus
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= {readA_pad, readB_pad};
         s2 <= s1;
      end
   end

   // Filter state register: state, candidate value and its stability count
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         cand  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cand  <= cand_n;
         cnt   <= cnt_n;
      end
   end

   // Filter next state: track a new candidate until it has been stable long enough
   always_comb begin
      state_n = state;
      cand_n  = cand;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            if (s2 != last_accepted) begin
               cand_n  = s2;
               cnt_n   = FW'(1);
               state_n = SETTLE;
            end
         end
         SETTLE: begin
            if (s2 != cand) begin
               cand_n = s2;
               cnt_n  = FW'(1);
               if (s2 == last_accepted) state_n = IDLE;
            end else begin
               cnt_n = cnt + FW'(1);
               if (cnt_n == FW'(STABLE_CYCLES)) state_n = COMMIT;
            end
         end
         COMMIT:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Filter output: COMMIT lasts one cycle and hands the candidate to the FIFO
   always_comb begin
      commit = 1'b0;
      if (state == COMMIT) commit = 1'b1;
   end

   // Remember the last committed pair so a return to it counts as a glitch
   always_ff @(posedge clk or posedge RST) begin
      if (RST)         last_accepted <= '0;
      else if (commit) last_accepted <= cand;
   end

   assign pop  = out_valid && out_ready;
   assign push = commit && ((count < CNTW'(DEPTH)) || pop);
   assign drop = commit && !push;

   // Occupancy update; simultaneous push and pop leaves the count unchanged
   always_comb begin
      count_n = count;
      case ({push, pop})
         2'b10:   count_n = count + CNTW'(1);
         2'b01:   count_n = count - CNTW'(1);
         default: count_n = count;
      endcase
   end

   // FIFO storage, pointers, count and registered valid
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         out_valid <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= cand;
            wr_ptr      <= wr_ptr + PTRW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTRW'(1);
         count     <= count_n;
         out_valid <= (count_n != '0);
      end
   end

   assign head  = mem[rd_ptr];
   assign readA = head[PW-1:WIDTH];
   assign readB = head[WIDTH-1:0];

`ifdef SJ_IN_OVF_CNT_EN
   // Saturating count of commits dropped against a full FIFO
   always_ff @(posedge clk or posedge RST) begin
      if (RST)                                ovf_count <= '0;
      else if (drop && (ovf_count != 8'hFF))  ovf_count <= ovf_count + 8'd1;
   end

   assign overflow = (ovf_count != 8'd0);
`else
   // Sticky flag: set on the first dropped commit, cleared only by reset
   always_ff @(posedge clk or posedge RST) begin
      if (RST)       overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_sj_input_stage.sv
// Bench for sj_input_stage: random and directed pad stimulus, run-length reference model,
// scoreboard queue of expected FIFO entries checked by a negedge monitor.
// Build with SJ_IN_OVF_CNT_EN defined to also exercise the saturating drop counter.
module tb_sj_input_stage;

   localparam int S = 4;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] a_pad = 8'h00;
   logic [7:0] b_pad = 8'h00;
   logic [7:0] ra, rb;
   logic       ov;
   logic       ordy = 1'b0;
   logic [2:0] cnt;
   logic       ovf;
`ifdef SJ_IN_OVF_CNT_EN
   logic [7:0] ovf_cnt;
`endif

   always #5 clk = ~clk;

   sj_input_stage #(.WIDTH(8), .STABLE_CYCLES(S), .DEPTH(D)) dut (
      .clk       (clk),
      .RST       (rst),
      .readA_pad (a_pad),
      .readB_pad (b_pad),
      .readA     (ra),
      .readB     (rb),
      .out_valid (ov),
      .out_ready (ordy),
      .count     (cnt),
      .overflow  (ovf)
`ifdef SJ_IN_OVF_CNT_EN
      ,
      .ovf_count (ovf_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Pads reach the filter two edges late; a value is accepted once it has been seen
   // S times in a row, differs from the last accepted pair, and was not seen on the
   // edge that performs the previous push (that edge ignores its sample).
   logic [15:0] p1 = '0, p2 = '0;
   logic [15:0] m_last = '0, run_val = '0, commit_val = '0;
   int          run_len = 0;
   bit          commit_pend = 0;
   int          m_count = 0;
   int          m_drops = 0;
   int          pops_seen = 0;
   logic [15:0] exp_q [$];

   always @(posedge clk) begin
      logic [15:0] x;
      bit          pop, did_commit;
      if (rst) begin
         p1 = '0; p2 = '0; m_last = '0; run_len = 0; commit_pend = 0;
         m_count = 0; m_drops = 0; exp_q.delete();
      end else begin
         x  = p2;
         p2 = p1;
         p1 = {a_pad, b_pad};
         pop = (m_count != 0) && ordy;
         did_commit = commit_pend;
         if (commit_pend) begin
            commit_pend = 0;
            if (m_count < D || pop) begin
               exp_q.push_back(commit_val);
               m_count++;
            end else begin
               m_drops++;
            end
         end
         if (pop) m_count--;
         if (did_commit)                       run_len = 0;
         else if (x == m_last)                 run_len = 0;
         else if (run_len > 0 && x == run_val) run_len++;
         else begin
            run_val = x;
            run_len = 1;
         end
         if (run_len == S) begin
            commit_pend = 1;
            commit_val  = run_val;
            m_last      = run_val;
            run_len     = 0;
         end
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [15:0] e;
      if (rst) begin
         check("rst_out_valid", ov, 0);
         check("rst_count", cnt, 0);
         check("rst_readA", ra, 0);
         check("rst_readB", rb, 0);
         check("rst_overflow", ovf, 0);
      end else begin
         check("out_valid", ov, (m_count != 0));
         check("count", cnt, m_count);
         check("overflow", ovf, (m_drops != 0));
`ifdef SJ_IN_OVF_CNT_EN
         check("ovf_count", ovf_cnt, (m_drops > 255) ? 255 : m_drops);
`endif
         if (ov && ordy) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_unexpected actual=%0h%0h expected=none at %0t", ra, rb, $time);
            end else begin
               e = exp_q.pop_front();
               check("head_readA", ra, e[15:8]);
               check("head_readB", rb, e[7:0]);
               pops_seen++;
            end
         end
      end
   end

   // ---------------- stimulus helpers (always entered/left at posedge+1) ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic hold(input logic [7:0] a, input logic [7:0] b, input int n);
      a_pad = a;
      b_pad = b;
      step(n);
   endtask

   task automatic hold_rand(input logic [7:0] a, input logic [7:0] b, input int n);
      a_pad = a;
      b_pad = b;
      repeat (n) begin
         ordy = ($urandom_range(0, 3) != 0);
         step(1);
      end
   endtask

   task automatic do_reset();
      a_pad = 8'h00;
      b_pad = 8'h00;
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(1);
   endtask

   // Count edges from the current point until out_valid is seen, bounded.
   task automatic wait_valid(input string name, input int exp_lat,
                             input logic [7:0] ea, input logic [7:0] eb);
      int n;
      n = 99;
      for (int k = 1; k <= 30; k++) begin
         step(1);
         if (ov) begin
            n = k;
            break;
         end
      end
      check({name, "_latency"}, n, exp_lat);
      check({name, "_readA"}, ra, ea);
      check({name, "_readB"}, rb, eb);
   endtask

   initial begin
      int p0;
      logic [7:0] v;

      // Power-on reset, idle
      step(3);
      rst = 1'b0;
      step(5);
      check("idle_count", cnt, 0);
      check("idle_valid", ov, 0);

      // 1: reset mid-run with pads at FF/FF, then full filter time after release
      ordy = 1'b1;
      hold(8'hFF, 8'hFF, 2);
      rst = 1'b1;
      step(3);
      rst = 1'b0;
      wait_valid("t1", S + 3, 8'hFF, 8'hFF);
      step(6);

      // 2: clean change, one push only
      p0 = pops_seen;
      a_pad = 8'h3C;
      b_pad = 8'h5A;
      wait_valid("t2", S + 3, 8'h3C, 8'h5A);
      step(15);
      check("t2_single_push", pops_seen, p0 + 1);

      // 3: glitch of 3 cycles returning to the accepted value
      hold(8'h00, 8'h00, 12);
      p0 = pops_seen;
      hold(8'h11, 8'h00, 3);
      hold(8'h00, 8'h00, 15);
      check("t3_no_push", pops_seen, p0);

      // 4: no drain, five distinct values -> full, head held, one drop
      ordy = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         v = 8'(i);
         hold(v, v, 7);
      end
      step(8);
      check("t4_count", cnt, 4);
      check("t4_head_A", ra, 8'h01);
      check("t4_head_B", rb, 8'h01);
      check("t4_overflow", ovf, 1);
      p0 = pops_seen;
      ordy = 1'b1;
      step(10);
      check("t4_drained", pops_seen, p0 + 4);

      // 5: commit coincides with pop while full -> no drop
      do_reset();
      ordy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         v = 8'h11 + 8'(i);
         hold(v, v, 10);
      end
      check("t5_full", cnt, 4);
      a_pad = 8'h15;
      b_pad = 8'h15;
      step(S + 2);
      ordy = 1'b1;
      step(1);
      ordy = 1'b0;
      step(3);
      check("t5_count", cnt, 4);
      check("t5_overflow", ovf, 0);
      ordy = 1'b1;
      step(12);

`ifdef SJ_IN_OVF_CNT_EN
      // 6: 300 drops saturate the counter
      do_reset();
      ordy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         v = 8'h31 + 8'(i);
         hold(v, v, 6);
      end
      for (int i = 0; i < 300; i++) begin
         v = 8'h40 + 8'(i % 2);
         hold(v, 8'h00, 6);
      end
      step(8);
      check("t6_ovf_count", ovf_cnt, 255);
      check("t6_overflow", ovf, 1);
      ordy = 1'b1;
      step(10);
`endif

      // Random phase: small alphabet, random hold lengths and ready
      do_reset();
      for (int i = 0; i < 400; i++) begin
         hold_rand(8'($urandom_range(0, 3)), 8'($urandom_range(0, 1) * 8'hA5),
                   $urandom_range(1, 8));
      end
      ordy = 1'b1;
      step(25);
      check("final_sb_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
